pipe_exmem_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_perf_ctr.sv | 33 +++
 rtl/pipe_exmem_stage.sv | 149 ++++++++++++++
 tb/tb_pipe_exmem_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM pipeline stage.
// - ctrl_t       : control bundle {rwrite, we, data_input_on, data_input_s, select_mem}
// - CTRL_BITS    : width of ctrl_t; bit-index localparams locate each field
// - occ_state_t  : skid-buffer occupancy (empty, one entry, two entries)
// - exmem_entry_t: fixed 32-bit payload variant for users that do not parametrise
package pipe_pkg;

  localparam int unsigned CTRL_BITS = 5;

  localparam int unsigned CtrlRwriteIdx      = 4;
  localparam int unsigned CtrlWeIdx          = 3;
  localparam int unsigned CtrlDataInputOnIdx = 2;
  localparam int unsigned CtrlDataInputSIdx  = 1;
  localparam int unsigned CtrlSelectMemIdx   = 0;

  typedef struct packed {
    logic rwrite;
    logic we;
    logic data_input_on;
    logic data_input_s;
    logic select_mem;
  } ctrl_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] data2;
    logic [31:0] inst;
    logic [3:0]  rd;
    ctrl_t       ctrl;
  } exmem_entry_t;

endpackage

// File: rtl/pipe_perf_ctr.sv
// Free-running 32-bit event counter; wraps at 2^32.
// Ports:
// - clk   : clock
// - reset : synchronous active-high clear
// - en    : count this cycle
// - cnt   : current count
module pipe_perf_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_exmem_stage.sv
// EX/MEM pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// in_ready is registered, so downstream stalls never form a combinational path
// back to execute. The main entry drives the outputs; the skid entry absorbs the
// one extra beat accepted while in_ready was still high.
// Ports:
// - clk, reset         : clock, synchronous active-high reset
// - flush              : synchronous squash of all held entries
// - in_valid/in_ready  : upstream handshake (in_ready registered)
// - in_*               : payload from execute
// - out_valid/out_ready: downstream handshake
// - out_*              : head payload; out_ctrl forced 0 when out_valid=0
// - stall_cnt, bubble_cnt: present only when PIPE_EXMEM_PERF_EN is defined
module pipe_exmem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 4,
  parameter int unsigned CTRL_W = CTRL_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_inst,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_inst,
  output logic [RD_W-1:0]   out_rd,
`ifdef PIPE_EXMEM_PERF_EN
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`else
  output logic [CTRL_W-1:0] out_ctrl
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] inst;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  occ_state_t state_q, state_d;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  logic       in_ready_q, in_ready_d;
  entry_t     in_ent;
  logic       accept, retire;

  assign in_ent = '{
    alu_result: in_alu_result,
    data2:      in_data2,
    inst:       in_inst,
    rd:         in_rd,
    ctrl:       in_ctrl
  };

  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready_q;
  assign retire    = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = in_ent;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && retire) begin
          main_d = in_ent;
        end else if (accept) begin
          skid_d  = in_ent;
          state_d = StTwo;
        end else if (retire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // in_ready is low here, so only a retire can move us.
        if (retire) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Payload may still load on flush; it is unobservable once state is empty.
    if (flush) begin
      state_d = StEmpty;
    end
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_alu_result = main_q.alu_result;
  assign out_data2      = main_q.data2;
  assign out_inst       = main_q.inst;
  assign out_rd         = main_q.rd;
  // Bubbles must never write the register file or memory.
  assign out_ctrl       = out_valid ? main_q.ctrl : '0;

`ifdef PIPE_EXMEM_PERF_EN
  pipe_perf_ctr u_stall_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (out_valid && !out_ready),
    .cnt   (stall_cnt)
  );

  pipe_perf_ctr u_bubble_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (!out_valid),
    .cnt   (bubble_cnt)
  );
`else
  // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_pipe_exmem_stage.sv
// Self-checking bench for pipe_exmem_stage: directed scenarios plus a random
// run against a queue-based reference model of a 2-deep FIFO.
module tb_pipe_exmem_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_alu_result, in_data2, in_inst;
  logic [3:0]  in_rd;
  logic [4:0]  in_ctrl;
  logic [31:0] out_alu_result, out_data2, out_inst;
  logic [3:0]  out_rd;
  logic [4:0]  out_ctrl;
`ifdef PIPE_EXMEM_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

  pipe_exmem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_result  (in_alu_result),
    .in_data2       (in_data2),
    .in_inst        (in_inst),
    .in_rd          (in_rd),
    .in_ctrl        (in_ctrl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_result (out_alu_result),
    .out_data2      (out_data2),
    .out_inst       (out_inst),
    .out_rd         (out_rd),
`ifdef PIPE_EXMEM_PERF_EN
    .out_ctrl       (out_ctrl),
    .stall_cnt      (stall_cnt),
    .bubble_cnt     (bubble_cnt)
`else
    .out_ctrl       (out_ctrl)
`endif
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] d2;
    logic [31:0] inst;
    logic [3:0]  rd;
    logic [4:0]  ctrl;
  } ent_t;

  ent_t        mq[$];
  int unsigned stall_m, bubble_m;
  int          n_checks = 0;
  int          n_fail = 0;

  // Reference: FIFO of capacity 2; ready means "not full" as of the last edge.
  task automatic tick();
    ent_t e;
    bit   acc, ret;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      stall_m  = 0;
      bubble_m = 0;
    end else begin
      if (mq.size() > 0 && !out_ready) stall_m++;
      if (mq.size() == 0) bubble_m++;
      if (flush) begin
        mq.delete();
      end else begin
        ret = (mq.size() > 0) && out_ready;
        acc = in_valid && (mq.size() < 2);
        e   = '{alu: in_alu_result, d2: in_data2, inst: in_inst, rd: in_rd, ctrl: in_ctrl};
        if (ret) void'(mq.pop_front());
        if (acc) mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] alu, input logic [3:0] rd,
                       input logic [4:0] ctrl);
    in_valid      = v;
    in_alu_result = alu;
    in_data2      = alu ^ 32'h5A5A_0000;
    in_inst       = ~alu;
    in_rd         = rd;
    in_ctrl       = ctrl;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b1; out_ready = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 4'hF, 5'h1F);
    tick(); tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_ctrl !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_ctl got rdy=%b v=%b ctrl=%h want 1 0 00", in_ready, out_valid, out_ctrl);
    end
    n_checks++;
    if ({out_alu_result, out_data2, out_inst, out_rd} !== '0) begin
      n_fail++;
      $display("FAIL reset_payload got %h %h %h %h want all 0", out_alu_result, out_data2,
               out_inst, out_rd);
    end
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 32'd0, 4'd0, 5'd0);
  endtask

  task automatic test_first();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_00A5, 4'd3, 5'b10000);
    tick();
    drive(1'b0, 32'd0, 4'd0, 5'd0);
    n_checks++;
    if (out_valid !== 1'b1 || out_alu_result !== 32'hA5 || out_rd !== 4'd3 ||
        out_ctrl !== 5'b10000) begin
      n_fail++;
      $display("FAIL first got v=%b alu=%h rd=%h ctrl=%b want 1 a5 3 10000", out_valid,
               out_alu_result, out_rd, out_ctrl);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 5'd0) begin
      n_fail++;
      $display("FAIL first_drain got v=%b ctrl=%b want 0 0", out_valid, out_ctrl);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 4'd1, 5'b00001);
    tick();
    drive(1'b1, 32'h22, 4'd2, 5'b00010);
    tick();
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_alu_result !== 32'h11) begin
      n_fail++;
      $display("FAIL bp_full got rdy=%b v=%b alu=%h want 0 1 11", in_ready, out_valid,
               out_alu_result);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_alu_result !== 32'h11) begin
      n_fail++;
      $display("FAIL bp_hold got rdy=%b alu=%h want 0 11", in_ready, out_alu_result);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_alu_result !== 32'h22 ||
        out_ctrl !== 5'b00010) begin
      n_fail++;
      $display("FAIL bp_second got rdy=%b v=%b alu=%h ctrl=%b want 1 1 22 00010", in_ready,
               out_valid, out_alu_result, out_ctrl);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 4'(i), 5'(i));
      tick();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_alu_result !== 32'(i)) begin
        n_fail++;
        $display("FAIL stream[%0d] got rdy=%b v=%b alu=%h want 1 1 %h", i, in_ready, out_valid,
                 out_alu_result, i);
      end
    end
    drive(1'b0, 32'd0, 4'd0, 5'd0);
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h31, 4'd1, 5'h1F);
    tick(); tick();
    // Full now; flush with a live input that must never emerge.
    drive(1'b1, 32'h99, 4'd9, 5'b11111);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 4'd0, 5'd0);
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 5'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_two got v=%b ctrl=%b rdy=%b want 0 0 1", out_valid, out_ctrl, in_ready);
    end
    // Flush in ONE with in_ready high: the presented input is discarded.
    drive(1'b1, 32'h44, 4'd4, 5'b10000);
    tick();
    drive(1'b1, 32'h77, 4'd7, 5'b11111);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 4'd0, 5'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 5'd0) begin
        n_fail++;
        $display("FAIL flush_one[%0d] got v=%b ctrl=%b want 0 0", i, out_valid, out_ctrl);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_two();
    out_ready = 1'b0;
    drive(1'b1, 32'h55, 4'd5, 5'h1F);
    tick(); tick();
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 32'd0, 4'd0, 5'd0);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_ctrl !== 5'd0 ||
        {out_alu_result, out_data2, out_inst, out_rd} !== '0) begin
      n_fail++;
      $display("FAIL rst_two got rdy=%b v=%b ctrl=%b alu=%h want 1 0 0 0", in_ready, out_valid,
               out_ctrl, out_alu_result);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_two_stale[%0d] got v=%b want 0", i, out_valid);
      end
    end
  endtask

`ifdef PIPE_EXMEM_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'hC0, 4'd1, 5'd1);
    tick();                            // idle cycle 1, entry accepted
    drive(1'b0, 32'd0, 4'd0, 5'd0);
    tick(); tick(); tick();            // three stalls
    out_ready = 1'b1;
    tick();                            // retire
    tick();                            // idle cycle 2
    n_checks++;
    if (stall_cnt !== 32'd3 || bubble_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_cnt got stall=%0d bubble=%0d want 3 2", stall_cnt, bubble_cnt);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (stall_cnt !== 32'd3 || bubble_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_flush got stall=%0d bubble=%0d want 3 3", stall_cnt, bubble_cnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset got stall=%0d bubble=%0d want 0 0", stall_cnt, bubble_cnt);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(99) == 0);
      flush     = ($urandom_range(39) == 0);
      out_ready = ($urandom_range(2) != 0);
      in_valid  = ($urandom_range(3) != 0);
      in_alu_result = $urandom();
      in_data2      = $urandom();
      in_inst       = $urandom();
      in_rd         = 4'($urandom_range(15));
      in_ctrl       = 5'($urandom_range(31));
      tick();
      n_checks++;
      if (in_ready !== (mq.size() < 2) || out_valid !== (mq.size() > 0)) begin
        n_fail++;
        $display("FAIL rand_hs[%0d] got rdy=%b v=%b want %b %b", c, in_ready, out_valid,
                 mq.size() < 2, mq.size() > 0);
      end
      if (mq.size() > 0) begin
        n_checks++;
        if ({out_alu_result, out_data2, out_inst, out_rd, out_ctrl} !== mq[0]) begin
          n_fail++;
          $display("FAIL rand_head[%0d] got %h %h %h %h %h want %h", c, out_alu_result,
                   out_data2, out_inst, out_rd, out_ctrl, mq[0]);
        end
      end else begin
        n_checks++;
        if (out_ctrl !== 5'd0) begin
          n_fail++;
          $display("FAIL rand_squash[%0d] got ctrl=%b want 0", c, out_ctrl);
        end
      end
`ifdef PIPE_EXMEM_PERF_EN
      n_checks++;
      if (stall_cnt !== 32'(stall_m) || bubble_cnt !== 32'(bubble_m)) begin
        n_fail++;
        $display("FAIL rand_perf[%0d] got %0d %0d want %0d %0d", c, stall_cnt, bubble_cnt,
                 stall_m, bubble_m);
      end
`endif
    end
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 32'd0, 4'd0, 5'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 4'd0, 5'd0);
    @(negedge clk);
    test_reset();
    test_first();
    test_back_pressure();
    test_stream();
    test_flush();
    test_reset_mid_two();
`ifdef PIPE_EXMEM_PERF_EN
    test_perf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
